// File: rtl/otbn_mac_bignum_mc.sv
// Multi-cycle bignum MAC: quarter-word product built from MulW-bit slices, accumulated into one of NumAcc ACCs.
// Optional OTBN_MAC_ZERO_SKIP_EN: a zero operand bypasses the MUL cycles and goes straight to ACC.
module otbn_mac_bignum_mc #(
  parameter int WLEN    = 256,
  parameter int MulW    = 16,
  parameter int NumAcc  = 2,
  parameter int AccIdxW = (NumAcc > 1) ? $clog2(NumAcc) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  output logic               ready_o,
  input  logic [WLEN-1:0]    operand_a_i,
  input  logic [WLEN-1:0]    operand_b_i,
  input  logic [1:0]         a_qw_sel_i,
  input  logic [1:0]         b_qw_sel_i,
  input  logic [1:0]         shift_imm_i,
  input  logic               zero_acc_i,
  input  logic               shift_acc_i,
  input  logic               wr_hw_sel_upper_i,
  input  logic [AccIdxW-1:0] acc_sel_i,
  output logic               done_o,
  output logic [WLEN-1:0]    result_o,
  output logic [3:0]         flags_o,
  output logic [3:0]         flags_en_o,
  input  logic [AccIdxW-1:0] ispr_acc_sel_i,
  output logic [WLEN-1:0]    ispr_acc_o,
  input  logic [WLEN-1:0]    ispr_acc_wr_data_i,
  input  logic               ispr_acc_wr_en_i
);
  localparam int QWLEN = WLEN / 4;
  localparam int PW    = 2 * QWLEN;
  localparam int Steps = QWLEN / MulW;
  localparam int StepW = (Steps > 1) ? $clog2(Steps) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ACC} state_e;
  state_e r_state, w_state_nxt;

  logic [QWLEN-1:0]   r_qa, r_qb;
  logic [PW-1:0]      r_prod;
  logic [StepW-1:0]   r_step;
  logic [1:0]         r_shift;
  logic               r_zero_acc, r_shift_acc, r_upper;
  logic [AccIdxW-1:0] r_acc_sel;
  logic [WLEN-1:0]    r_acc [NumAcc];
  logic [WLEN-1:0]    r_result;
  logic [3:0]         r_flags, r_flags_en;
  logic               r_done;

  logic [QWLEN-1:0] w_qa_in, w_qb_in;
  logic [MulW-1:0]  w_slice;
  logic [PW-1:0]    w_pp, w_pp_sh;
  logic [WLEN-1:0]  w_acc_in, w_prod_sh, w_sum, w_acc_wr;
  logic             w_accept, w_last_step, w_lo_zero;
  logic [3:0]       w_flags, w_flags_en;

  assign w_qa_in     = operand_a_i[a_qw_sel_i*QWLEN +: QWLEN];
  assign w_qb_in     = operand_b_i[b_qw_sel_i*QWLEN +: QWLEN];
  assign w_accept    = start_i && (r_state == ST_IDLE);
  assign w_last_step = (r_step == StepW'(Steps - 1));

  assign w_slice = r_qb[r_step*MulW +: MulW];
  assign w_pp    = PW'(r_qa) * PW'(w_slice);
  assign w_pp_sh = w_pp << (r_step * MulW);

  // Shifting in WLEN width drops the product's upper bits for shift 3 by construction.
  assign w_acc_in  = r_zero_acc ? '0 : r_acc[r_acc_sel];
  assign w_prod_sh = {{(WLEN-PW){1'b0}}, r_prod} << (r_shift * QWLEN);
  assign w_sum     = w_prod_sh + w_acc_in;
  assign w_acc_wr  = r_shift_acc ? {{(WLEN/2){1'b0}}, w_sum[WLEN-1:WLEN/2]} : w_sum;
  assign w_lo_zero = (w_sum[WLEN/2-1:0] == '0);

  always_comb begin
    w_flags       = 4'b0000;
    w_flags_en    = 4'b0000;
    w_flags[2]    = w_sum[0];
    w_flags[1]    = r_shift_acc ? w_sum[WLEN/2-1] : w_sum[WLEN-1];
    w_flags[3]    = r_shift_acc ? w_lo_zero : (w_sum == '0);
    w_flags_en[2] = r_shift_acc ? ~r_upper : 1'b1;
    w_flags_en[1] = r_shift_acc ? r_upper : 1'b1;
    w_flags_en[3] = (r_shift_acc && r_upper) ? ~w_lo_zero : 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
`ifdef OTBN_MAC_ZERO_SKIP_EN
          w_state_nxt = ((w_qa_in == '0) || (w_qb_in == '0)) ? ST_ACC : ST_MUL;
`else
          w_state_nxt = ST_MUL;
`endif
        end
      end
      ST_MUL:  if (w_last_step) w_state_nxt = ST_ACC;
      ST_ACC:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_qa        <= '0;
      r_qb        <= '0;
      r_prod      <= '0;
      r_step      <= '0;
      r_shift     <= '0;
      r_zero_acc  <= 1'b0;
      r_shift_acc <= 1'b0;
      r_upper     <= 1'b0;
      r_acc_sel   <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_flags_en  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_qa        <= w_qa_in;
        r_qb        <= w_qb_in;
        r_shift     <= shift_imm_i;
        r_zero_acc  <= zero_acc_i;
        r_shift_acc <= shift_acc_i;
        r_upper     <= wr_hw_sel_upper_i;
        r_acc_sel   <= acc_sel_i;
        r_prod      <= '0;
        r_step      <= '0;
      end else if (r_state == ST_MUL) begin
        r_prod <= r_prod + w_pp_sh;
        r_step <= r_step + StepW'(1);
      end
      if (r_state == ST_ACC) begin
        r_result   <= w_sum;
        r_flags    <= w_flags;
        r_flags_en <= w_flags_en;
        r_done     <= 1'b1;
      end
    end
  end

  // ISPR write takes priority over the MAC write-back to the same accumulator.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumAcc; i++) r_acc[i] <= '0;
    end else begin
      for (int i = 0; i < NumAcc; i++) begin
        if (ispr_acc_wr_en_i && (ispr_acc_sel_i == AccIdxW'(i)))
          r_acc[i] <= ispr_acc_wr_data_i;
        else if ((r_state == ST_ACC) && (r_acc_sel == AccIdxW'(i)))
          r_acc[i] <= w_acc_wr;
      end
    end
  end

  assign ready_o    = (r_state == ST_IDLE);
  assign done_o     = r_done;
  assign result_o   = r_result;
  assign flags_o    = r_flags;
  assign flags_en_o = r_flags_en;
  assign ispr_acc_o = r_acc[ispr_acc_sel_i];
endmodule

// File: tb/tb_otbn_mac_bignum_mc.sv
// Directed self-checking bench for otbn_mac_bignum_mc (default parameters).
module tb_otbn_mac_bignum_mc;
  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic         ready_o;
  logic [255:0] opa = '0, opb = '0;
  logic [1:0]   a_sel = '0, b_sel = '0, shift_imm = '0;
  logic         zero_acc = 1'b0, shift_acc = 1'b0, upper = 1'b0;
  logic         acc_sel = 1'b0;
  logic         done_o;
  logic [255:0] result_o;
  logic [3:0]   flags_o, flags_en_o;
  logic         ispr_sel = 1'b0;
  logic [255:0] ispr_acc_o;
  logic [255:0] ispr_wdata = '0;
  logic         ispr_wen = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] Ones64 = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  otbn_mac_bignum_mc dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o),
    .operand_a_i(opa), .operand_b_i(opb), .a_qw_sel_i(a_sel), .b_qw_sel_i(b_sel),
    .shift_imm_i(shift_imm), .zero_acc_i(zero_acc), .shift_acc_i(shift_acc),
    .wr_hw_sel_upper_i(upper), .acc_sel_i(acc_sel), .done_o(done_o), .result_o(result_o),
    .flags_o(flags_o), .flags_en_o(flags_en_o), .ispr_acc_sel_i(ispr_sel),
    .ispr_acc_o(ispr_acc_o), .ispr_acc_wr_data_i(ispr_wdata), .ispr_acc_wr_en_i(ispr_wen)
  );

  task automatic set_op(input logic [255:0] a, input logic [255:0] b, input logic [1:0] as,
                        input logic [1:0] bs, input logic [1:0] sh, input logic za,
                        input logic sa, input logic up, input logic sel);
    opa = a; opb = b; a_sel = as; b_sel = bs; shift_imm = sh;
    zero_acc = za; shift_acc = sa; upper = up; acc_sel = sel;
  endtask

  // Issues one operation and returns the cycle index (1 = first cycle after accept) of done_o.
  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [1:0] as,
                        input logic [1:0] bs, input logic [1:0] sh, input logic za,
                        input logic sa, input logic up, input logic sel, output int lat);
    @(posedge clk); #1;
    set_op(a, b, as, bs, sh, za, sa, up, sel);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_o) begin lat = k; break; end
    end
  endtask

  task automatic ispr_write(input logic sel, input logic [255:0] d);
    @(posedge clk); #1;
    ispr_sel = sel; ispr_wdata = d; ispr_wen = 1'b1;
    @(posedge clk); #1;
    ispr_wen = 1'b0; ispr_sel = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL reset_hs: ready=%b done=%b, want ready=1 done=0", ready_o, done_o);
    end
    checks++;
    if (result_o !== '0 || flags_o !== 4'h0 || flags_en_o !== 4'h0) begin
      errors++; $display("FAIL reset_out: result=%h flags=%b en=%b, want 0", result_o, flags_o, flags_en_o);
    end
    ispr_sel = 1'b1; #1;
    checks++;
    if (ispr_acc_o !== '0) begin
      errors++; $display("FAIL reset_acc1: got %h, want 0", ispr_acc_o);
    end
    ispr_sel = 1'b0;
  endtask

  task automatic test_full_width();
    int lat;
    run_op({192'd0, Ones64}, {64'd0, Ones64, 128'd0}, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL full_lat: got %0d, want 6", lat); end
    checks++;
    if (result_o !== {128'd0, 128'hFFFFFFFFFFFFFFFE_0000000000000001}) begin
      errors++; $display("FAIL full_result: got %h, want fffffffffffffffe0000000000000001", result_o);
    end
    checks++;
    if (flags_o !== 4'b0100 || flags_en_o !== 4'b1110) begin
      errors++; $display("FAIL full_flags: flags=%b en=%b, want 0100/1110", flags_o, flags_en_o);
    end
    checks++;
    if (ispr_acc_o !== {128'd0, 128'hFFFFFFFFFFFFFFFE_0000000000000001}) begin
      errors++; $display("FAIL full_acc0: got %h", ispr_acc_o);
    end
  endtask

  task automatic test_so();
    int lat;
    ispr_write(1'b1, {127'd0, 1'b1, 128'd5});
    run_op({192'd0, 64'd3}, {192'd0, 64'd4}, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, lat);
    checks++;
    if (result_o !== {127'd0, 1'b1, 128'd17}) begin
      errors++; $display("FAIL so_lo_result: got %h, want 2^128+17", result_o);
    end
    checks++;
    if (flags_o !== 4'b0100 || flags_en_o !== 4'b1100) begin
      errors++; $display("FAIL so_lo_flags: flags=%b en=%b, want 0100/1100", flags_o, flags_en_o);
    end
    ispr_sel = 1'b1; #1;
    checks++;
    if (ispr_acc_o !== 256'd1) begin errors++; $display("FAIL so_lo_acc1: got %h, want 1", ispr_acc_o); end
    ispr_sel = 1'b0;
    // Upper-half write with an all-zero low half: Z is set but not enabled.
    run_op({192'd0, 64'd1}, {192'd0, 64'd1}, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, lat);
    checks++;
    if (result_o !== {127'd0, 1'b1, 128'd0}) begin
      errors++; $display("FAIL so_hi_result: got %h, want 2^128", result_o);
    end
    checks++;
    if (flags_o !== 4'b1000 || flags_en_o !== 4'b0010) begin
      errors++; $display("FAIL so_hi_flags: flags=%b en=%b, want 1000/0010", flags_o, flags_en_o);
    end
  endtask

  task automatic test_shift();
    int lat;
    run_op({128'd0, 64'd2, 64'd0}, {128'd0, 64'd3, 64'd0}, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (result_o !== {128'd0, 64'd6, 64'd0}) begin
      errors++; $display("FAIL shift1_result: got %h, want 6<<64", result_o);
    end
    run_op({Ones64, 192'd0}, {Ones64, 192'd0}, 2'd3, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (result_o !== {64'd1, 192'd0}) begin
      errors++; $display("FAIL shift3_result: got %h, want 1<<192", result_o);
    end
    checks++;
    if (flags_o !== 4'b0000 || flags_en_o !== 4'b1110) begin
      errors++; $display("FAIL shift3_flags: flags=%b en=%b, want 0000/1110", flags_o, flags_en_o);
    end
  endtask

  task automatic test_zero_skip();
    int lat;
    int want_lat;
`ifdef OTBN_MAC_ZERO_SKIP_EN
    want_lat = 2;
`else
    want_lat = 6;
`endif
    run_op(256'd0, {192'd0, 64'd5}, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== want_lat) begin errors++; $display("FAIL zskip_lat: got %0d, want %0d", lat, want_lat); end
    checks++;
    if (result_o !== {64'd1, 192'd0}) begin
      errors++; $display("FAIL zskip_result: got %h, want 1<<192", result_o);
    end
  endtask

  // c=0: ISPR write to acc0 collides with the MAC write; c=1: ISPR write to acc1 alongside it.
  task automatic test_ispr_collision();
    logic [255:0] want_res, want_a0, want_a1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      set_op({192'd0, 64'd5}, {192'd0, 64'd7}, 2'd0, 2'd0, 2'd0, (c == 0), 1'b0, 1'b0, 1'b0);
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      ispr_sel = (c == 1); ispr_wdata = (c == 0) ? 256'hAA : 256'h55; ispr_wen = 1'b1;
      @(posedge clk); #1;
      ispr_wen = 1'b0;
      @(negedge clk);
      want_res = (c == 0) ? 256'd35 : 256'd205;
      want_a0  = (c == 0) ? 256'hAA : 256'd205;
      want_a1  = 256'h55;
      checks++;
      if (done_o !== 1'b1 || result_o !== want_res) begin
        errors++; $display("FAIL coll%0d_result: done=%b result=%h, want done=1 result=%h", c, done_o, result_o, want_res);
      end
      ispr_sel = 1'b0; #1;
      checks++;
      if (ispr_acc_o !== want_a0) begin
        errors++; $display("FAIL coll%0d_acc0: got %h, want %h", c, ispr_acc_o, want_a0);
      end
      if (c == 1) begin
        ispr_sel = 1'b1; #1;
        checks++;
        if (ispr_acc_o !== want_a1) begin
          errors++; $display("FAIL coll%0d_acc1: got %h, want %h", c, ispr_acc_o, want_a1);
        end
        ispr_sel = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int first, second, ndone;
    @(posedge clk); #1;
    set_op({192'd0, 64'd2}, {192'd0, 64'd3}, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    @(posedge clk);
    first = -1; second = -1; ndone = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (done_o) begin
        ndone++;
        if (first < 0) begin
          first = k;
          @(posedge clk); #1;
          start_i = 1'b0;
        end else begin
          second = k;
        end
      end
    end
    start_i = 1'b0;
    checks++;
    if (first !== 6 || second !== 12 || ndone !== 2) begin
      errors++; $display("FAIL b2b_timing: first=%0d second=%0d count=%0d, want 6/12/2", first, second, ndone);
    end
    checks++;
    if (result_o !== 256'd6) begin errors++; $display("FAIL b2b_result: got %h, want 6", result_o); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(posedge clk); #1;
    set_op({192'd0, 64'd9}, {192'd0, 64'd9}, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== '0 || flags_o !== 4'h0) begin
      errors++; $display("FAIL rstmid_state: ready=%b result=%h flags=%b, want 1/0/0", ready_o, result_o, flags_o);
    end
    ispr_sel = 1'b0; #1;
    checks++;
    if (ispr_acc_o !== '0) begin errors++; $display("FAIL rstmid_acc0: got %h, want 0", ispr_acc_o); end
    ispr_sel = 1'b1; #1;
    checks++;
    if (ispr_acc_o !== '0) begin errors++; $display("FAIL rstmid_acc1: got %h, want 0", ispr_acc_o); end
    ispr_sel = 1'b0;
    ndone = done_o ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses, want 0", ndone); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_width();
    test_so();
    test_shift();
    test_zero_skip();
    test_ispr_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
